// File: rtl/cfifo_n_ctrl.sv
// cfifo_n_ctrl: parametrised token FIFO controller with per-stage load enables,
// occupancy count, sticky overflow flag, synchronous flush and output delay line.
module cfifo_n_ctrl #(
    parameter int DEPTH = 2,
    parameter int OUT_DELAY = 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_drive,
    input  logic             i_freeNext,
    input  logic             i_flush,
    output logic             o_free,
    output logic             o_driveNext,
    output logic [DEPTH-1:0] o_fire,
    output logic [CW-1:0]    o_count,
    output logic             o_err
);
    logic [DEPTH-1:0]     full_q, full_d;
    logic [OUT_DELAY-1:0] dl_q, dl_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 err_q, err_d;
    logic [DEPTH:0]       mv;
    logic [DEPTH:0]       src;
    logic                 leave, acc;

    // mv[DEPTH] holds leave, so the vacancy of stage k is always mv[k+1].
    always_comb begin
        src = {full_q, i_drive & ~i_flush};
        leave = full_q[DEPTH-1] & i_freeNext & ~i_flush;
        mv = '0;
        mv[DEPTH] = leave;
        for (int k = DEPTH - 1; k >= 0; k--)
            mv[k] = src[k] & (~full_q[k] | (k != 0 && mv[k+1]));
        acc = mv[0];
        full_d = i_flush ? '0 : (mv[DEPTH-1:0] | (full_q & ~mv[DEPTH:1]));
        dl_d = i_flush ? '0 : ((dl_q << 1) | OUT_DELAY'(leave));
        count_d = i_flush ? '0 : (count_q + CW'(acc) - CW'(leave));
        err_d = ~i_flush & (err_q | (i_drive & full_q[0]));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_q  <= '0;
            dl_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            dl_q    <= dl_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign o_fire      = (rstn & ~i_flush) ? mv[DEPTH-1:0] : '0;
    assign o_free      = ~full_q[0];
    assign o_driveNext = dl_q[OUT_DELAY-1];
    assign o_count     = count_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_cfifo_n_ctrl.sv
// tb_cfifo_n_ctrl: directed scenarios for cfifo_n_ctrl with DEPTH=4, OUT_DELAY=2.
module tb_cfifo_n_ctrl;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       i_drive = 1'b0;
    logic       i_freeNext = 1'b0;
    logic       i_flush = 1'b0;
    logic       o_free;
    logic       o_driveNext;
    logic [3:0] o_fire;
    logic [2:0] o_count;
    logic       o_err;
    int total = 0;
    int bad = 0;

    cfifo_n_ctrl #(.DEPTH(4), .OUT_DELAY(2)) dut (
        .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_freeNext(i_freeNext),
        .i_flush(i_flush), .o_free(o_free), .o_driveNext(o_driveNext),
        .o_fire(o_fire), .o_count(o_count), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_drive = 1'b1;
        #3;
        total++; if (o_free !== 1'b1) begin bad++; $display("FAIL reset_free got=%b exp=1", o_free); end
        total++; if (o_driveNext !== 1'b0) begin bad++; $display("FAIL reset_dn got=%b exp=0", o_driveNext); end
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_err); end
        total++; if (o_fire !== 4'b0000) begin bad++; $display("FAIL reset_fire got=%b exp=0000", o_fire); end
        step();
        i_drive = 1'b0;
        rstn = 1'b1;
        step();
    endtask

    task automatic run_single(input string tag);
        logic [3:0] ef;
        logic [2:0] ec;
        i_freeNext = 1'b1;
        for (int c = 0; c < 10; c++) begin
            i_drive = (c == 0);
            ef = (c < 4) ? (4'b0001 << c) : 4'b0000;
            ec = (c >= 1 && c <= 4) ? 3'd1 : 3'd0;
            #3;
            total++; if (o_fire !== ef) begin bad++; $display("FAIL %s_fire c=%0d got=%b exp=%b", tag, c, o_fire, ef); end
            total++; if (o_driveNext !== (c == 6)) begin bad++; $display("FAIL %s_dn c=%0d got=%b exp=%b", tag, c, o_driveNext, c == 6); end
            total++; if (o_count !== ec) begin bad++; $display("FAIL %s_count c=%0d got=%0d exp=%0d", tag, c, o_count, ec); end
            step();
        end
        i_drive = 1'b0;
    endtask

    task automatic test_single();
        run_single("single");
    endtask

    task automatic test_fill();
        int acc = 0;
        int pulses = 0;
        int first = -1;
        int last = -1;
        i_freeNext = 1'b0;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            i_drive = o_free;
            if (o_free) acc++;
            step();
        end
        i_drive = 1'b0;
        total++; if (acc !== 4) begin bad++; $display("FAIL fill_accepts got=%0d exp=4", acc); end
        repeat (6) step();
        #3;
        total++; if (o_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", o_count); end
        total++; if (o_free !== 1'b0) begin bad++; $display("FAIL fill_free got=%b exp=0", o_free); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL fill_err_pre got=%b exp=0", o_err); end
        step();
        i_drive = 1'b1;
        step();
        i_drive = 1'b0;
        #3;
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL fill_err got=%b exp=1", o_err); end
        total++; if (o_count !== 3'd4) begin bad++; $display("FAIL fill_count_rej got=%0d exp=4", o_count); end
        step();
        i_freeNext = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #3;
            if (o_driveNext) begin
                pulses++;
                if (first < 0) first = c;
                last = c;
            end
            step();
        end
        total++; if (pulses !== 4) begin bad++; $display("FAIL drain_pulses got=%0d exp=4", pulses); end
        total++; if (last - first !== 3) begin bad++; $display("FAIL drain_span got=%0d exp=3", last - first); end
    endtask

    task automatic test_simul();
        i_freeNext = 1'b0;
        for (int c = 0; c < 10; c++) begin
            i_drive = (c == 0 || c == 2);
            step();
        end
        i_drive = 1'b0;
        #3;
        total++; if (o_count !== 3'd2) begin bad++; $display("FAIL simul_count_pre got=%0d exp=2", o_count); end
        step();
        i_freeNext = 1'b1;
        i_drive = 1'b1;
        #3;
        total++; if (o_fire !== 4'b1001) begin bad++; $display("FAIL simul_fire got=%b exp=1001", o_fire); end
        step();
        i_drive = 1'b0;
        i_freeNext = 1'b0;
        #3;
        total++; if (o_count !== 3'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", o_count); end
        step();
        i_freeNext = 1'b1;
        repeat (12) step();
    endtask

    task automatic test_flush();
        int pulses = 0;
        i_freeNext = 1'b0;
        for (int c = 0; c < 12; c++) begin
            i_drive = (c == 0 || c == 2 || c == 4 || c == 6 || c == 9);
            step();
        end
        i_drive = 1'b0;
        #3;
        total++; if (o_count !== 3'd4) begin bad++; $display("FAIL flush_setup_count got=%0d exp=4", o_count); end
        step();
        i_freeNext = 1'b1;
        step();
        i_freeNext = 1'b0;
        i_flush = 1'b1;
        i_drive = 1'b1;
        #3;
        total++; if (o_fire !== 4'b0000) begin bad++; $display("FAIL flush_fire got=%b exp=0000", o_fire); end
        total++; if (o_count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", o_count); end
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL flush_pre_err got=%b exp=1", o_err); end
        step();
        i_flush = 1'b0;
        i_drive = 1'b0;
        #3;
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", o_count); end
        total++; if (o_free !== 1'b1) begin bad++; $display("FAIL flush_free got=%b exp=1", o_free); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL flush_err got=%b exp=0", o_err); end
        for (int c = 0; c < 6; c++) begin
            if (o_driveNext) pulses++;
            step();
            #3;
        end
        step();
        total++; if (pulses !== 0) begin bad++; $display("FAIL flush_dn got=%0d exp=0", pulses); end
    endtask

    task automatic test_async();
        i_freeNext = 1'b0;
        for (int c = 0; c < 8; c++) begin
            i_drive = (c <= 2);
            step();
        end
        i_drive = 1'b0;
        total++; if (o_count !== 3'd2) begin bad++; $display("FAIL async_pre_count got=%0d exp=2", o_count); end
        total++; if (o_err !== 1'b1) begin bad++; $display("FAIL async_pre_err got=%b exp=1", o_err); end
        #2;
        rstn = 1'b0;
        i_drive = 1'b1;
        #1;
        total++; if (o_count !== 3'd0) begin bad++; $display("FAIL async_count got=%0d exp=0", o_count); end
        total++; if (o_free !== 1'b1) begin bad++; $display("FAIL async_free got=%b exp=1", o_free); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL async_err got=%b exp=0", o_err); end
        total++; if (o_fire !== 4'b0000) begin bad++; $display("FAIL async_fire got=%b exp=0000", o_fire); end
        #2;
        i_drive = 1'b0;
        rstn = 1'b1;
        step();
        run_single("async_single");
        repeat (4) step();
    endtask

    task automatic test_order();
        int acc = 0;
        int pulses = 0;
        int maxc = 0;
        for (int c = 0; c < 140; c++) begin
            i_freeNext = (c >= 120) ? 1'b1 : 1'($urandom_range(0, 1));
            i_drive = (acc < 8) && o_free;
            if (i_drive) acc++;
            #3;
            if (o_driveNext) pulses++;
            if (int'(o_count) > maxc) maxc = int'(o_count);
            step();
        end
        i_drive = 1'b0;
        total++; if (acc !== 8) begin bad++; $display("FAIL order_accepts got=%0d exp=8", acc); end
        total++; if (pulses !== 8) begin bad++; $display("FAIL order_pulses got=%0d exp=8", pulses); end
        total++; if (maxc > 4) begin bad++; $display("FAIL order_maxcount got=%0d exp<=4", maxc); end
        total++; if (o_err !== 1'b0) begin bad++; $display("FAIL order_err got=%b exp=0", o_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_flush();
        test_async();
        test_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cfifo_n_ctrl.md
# cfifo_n_ctrl

Clocked, parametrised successor to the two-stage handshake FIFO controller in the MMU. It tracks up to DEPTH tokens through a chain of stages and issues one load-enable pulse (fire) per stage for the external datapath registers. It adds occupancy reporting, an overflow error flag, a synchronous flush and a configurable output delay line. It sits between an MMU request producer (i_drive/o_free) and its consumer (o_driveNext/i_freeNext).

## Interface
- DEPTH, 2, number of stages; legal range 1 or more.
- OUT_DELAY, 1, cycles between a token leaving the last stage and o_driveNext; legal range 1 or more.
- CW (localparam), $clog2(DEPTH+1), occupancy width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- i_drive  in  1  one-cycle token offer from upstream.
- i_freeNext  in  1  level; downstream can take a token this cycle.
- i_flush  in  1  synchronous clear of all tokens.
- o_free  out  1  level; stage 0 empty, so an i_drive is accepted.
- o_driveNext  out  1  one-cycle token hand-off pulse to downstream.
- o_fire  out  DEPTH  combinational per-stage load enable; bit k is high in the cycle stage k loads.
- o_count  out  CW  tokens held in stages; the delay line is excluded.
- o_err  out  1  sticky; an i_drive arrived while o_free was 0.

## Operation
- State:
  - full[DEPTH-1:0], one bit per stage.
  - dl[OUT_DELAY-1:0], delay shift register.
  - count[CW-1:0].
  - err.
- Per-cycle terms (all combinational, ignored when i_flush=1):
  - leave = full[DEPTH-1] & i_freeNext.
  - vac[DEPTH-1] = leave.
  - For k < DEPTH-1: vac[k] = mv[k+1].
  - For k ≥ 1: mv[k] = full[k-1] & (~full[k] | vac[k]), the bubble-collapse chain evaluated from the last stage backwards.
  - acc = i_drive & ~full[0].
  - mv[0] = acc.
- Outputs:
  - o_fire[k] = mv[k].
  - o_free = ~full[0].
  - o_driveNext = dl[OUT_DELAY-1].
  - o_count = count.
  - o_err = err.
- Update:
  - full[k] <= mv[k] | (full[k] & ~vac[k]).
  - dl <= {dl[OUT_DELAY-2:0], leave}.
  - count <= count + acc - leave. count never exceeds DEPTH.
  - err <= err | (i_drive & full[0]).
- Rejected drive: an i_drive while full[0]=1 is dropped, not queued, and sets err.
- Flush (i_flush=1) at the next edge:
  - full, dl, count and err clear.
  - o_fire is forced 0 that cycle.
  - i_drive is ignored and does not set err.
  - Pulses already in dl are discarded; no o_driveNext follows a flush.
- Tokens never overtake; order is preserved.

## Timing
- Reset, asynchronous and immediate:
  - full=0, dl=0, count=0, err=0.
  - Outputs: o_free=1, o_driveNext=0, o_count=0, o_err=0.
  - o_fire is forced 0 while rstn=0.
- Accept: a token driven in cycle 0 gives o_fire[0] in cycle 0. With no stall, o_fire[k] follows in cycle k.
- With i_freeNext=1 throughout, leave occurs in cycle DEPTH and o_driveNext pulses in cycle DEPTH+OUT_DELAY. Total latency is DEPTH+OUT_DELAY cycles.
- Input rate:
  - At most one accept every 2 cycles: full[0] is set for at least 1 cycle after an accept.
  - o_free has no combinational path from i_freeNext.
- Output rate: a full chain with i_freeNext=1 drains one token per cycle. Stage DEPTH-1 reloads in the same cycle it empties.
- i_freeNext low stalls leave only. Upstream stages keep collapsing bubbles until the chain is full.
- Simultaneous acc and leave: count is unchanged.
- DEPTH=1: mv[0]=acc only. An accept into a stage that is leaving in the same cycle is not allowed, since o_free=0.
- Reset mid-operation: all tokens and in-flight dl pulses are lost; no o_driveNext follows.

## Test plan
All scenarios use DEPTH=4, OUT_DELAY=2.
- **Single token.** i_drive in cycle 0, i_freeNext=1 -> o_fire = 0001, 0010, 0100, 1000 in cycles 0–3; o_driveNext high in cycle 6 only; o_count returns to 0 at cycle 5.
- **Fill under backpressure.** i_freeNext=0, i_drive whenever o_free=1 -> 4 accepts, then o_count=4 and o_free=0. A 5th i_drive sets o_err=1 and o_count stays 4. Raising i_freeNext then gives 4 o_driveNext pulses in 4 consecutive cycles.
- **Simultaneous accept and leave.** With o_count=2 and stage 3 full, i_freeNext=1 and i_drive in the same cycle -> o_count stays 2 and o_fire[0]=1.
- **Flush.** With 3 tokens held and 1 pulse in dl, assert i_flush together with i_drive -> next cycle o_count=0, o_free=1, o_err=0; o_fire=0 in the flush cycle; no o_driveNext afterwards.
- **Async reset.** Drop rstn mid-cycle with 2 tokens held -> outputs take their reset values immediately, without waiting for a clock edge. After release, a single token still gives 6-cycle latency.
- **Ordering.** 8 tokens under random i_freeNext -> exactly 8 o_driveNext pulses; o_count is never above 4; o_err=0.
